// File: rtl/alu_div_seq.sv
// Sequential unsigned divider: one subtract per clock, START/BUSY/DONE handshake.
// Define ALU_DIV_REM_EN to drive REM; otherwise REM is tied to zero.
module alu_div_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] QUO,
  output logic [WIDTH-1:0] REM,
  output logic             DZ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] quo_r;
  logic             dz_r;
  logic             busy_r;
  logic             done_r;
`ifdef ALU_DIV_REM_EN
  logic [WIDTH-1:0] rem_r;
`endif

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state  <= S_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      cnt    <= '0;
      quo_r  <= '0;
      dz_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
`ifdef ALU_DIV_REM_EN
      rem_r  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done_r <= 1'b0;
          if (START) begin
            a_r    <= A;
            b_r    <= B;
            cnt    <= '0;
            busy_r <= 1'b1;
            if (B == '0) begin
              // Divide by zero finishes immediately with saturated quotient.
              state  <= S_DONE;
              done_r <= 1'b1;
              quo_r  <= '1;
              dz_r   <= 1'b1;
`ifdef ALU_DIV_REM_EN
              rem_r  <= A;
`endif
            end else begin
              state <= S_SUB;
            end
          end
        end
        S_SUB: begin
          // Compare before subtracting so a_r never underflows.
          if (a_r >= b_r) begin
            a_r <= a_r - b_r;
            cnt <= cnt + WIDTH'(1);
          end else begin
            state  <= S_DONE;
            done_r <= 1'b1;
            quo_r  <= cnt;
            dz_r   <= 1'b0;
`ifdef ALU_DIV_REM_EN
            rem_r  <= a_r;
`endif
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY = busy_r;
  assign DONE = done_r;
  assign QUO  = quo_r;
  assign DZ   = dz_r;
`ifdef ALU_DIV_REM_EN
  assign REM  = rem_r;
`else
  assign REM  = '0;
`endif

endmodule

// File: tb/tb_alu_div_seq.sv
// Scoreboard bench for alu_div_seq: driver queues expected results, monitor checks each DONE.
module tb_alu_div_seq;

  logic       CLK;
  logic       CLR_N;
  logic       START;
  logic [7:0] A;
  logic [7:0] B;
  logic       BUSY;
  logic       DONE;
  logic [7:0] QUO;
  logic [7:0] REM;
  logic       DZ;

  alu_div_seq #(.WIDTH(8)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .START(START), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .QUO(QUO), .REM(REM), .DZ(DZ)
  );

  typedef struct {
    int quo;
    int rem;
    int dz;
    int k;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   edge_cnt = 0;
  int   last_quo = 0, last_rem = 0, last_dz = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, edge_cnt);
    end
  endfunction

  // Reference: plain integer division; k is the edge that samples START.
  function automatic exp_t model(input int a, input int b, input int k);
    exp_t e;
    e.k   = k;
    e.dz  = (b == 0) ? 1 : 0;
    e.quo = (b == 0) ? 255 : a / b;
    e.lat = (b == 0) ? 0 : a / b + 1;
`ifdef ALU_DIV_REM_EN
    e.rem = (b == 0) ? a : a % b;
`else
    e.rem = 0;
`endif
    return e;
  endfunction

  // Monitor: samples 1ns after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      edge_cnt++;
      #1;
      if (!CLR_N) begin
        last_quo = 0; last_rem = 0; last_dz = 0;
      end else if (DONE) begin
        check("busy_during_done", int'(BUSY), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("quo", int'(QUO), e.quo);
          check("rem", int'(REM), e.rem);
          check("dz", int'(DZ), e.dz);
          check("latency", edge_cnt - e.k, e.lat);
          last_quo = e.quo; last_rem = e.rem; last_dz = e.dz;
        end
      end else begin
        check("quo_held", int'(QUO), last_quo);
        check("rem_held", int'(REM), last_rem);
        check("dz_held", int'(DZ), last_dz);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after START was sampled.
  task automatic issue(input int a, input int b);
    int guard = 0;
    while (BUSY && guard < 1000) begin
      @(negedge CLK);
      guard++;
    end
    if (BUSY) check("idle_timeout", 1, 0);
    exp_q.push_back(model(a, b, edge_cnt + 1));
    A = 8'(a);
    B = 8'(b);
    START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() != 0 || BUSY) && guard < 2000) begin
      @(negedge CLK);
      guard++;
    end
    check("drain_timeout", exp_q.size() + int'(BUSY), 0);
  endtask

  initial begin
    int busy_len;
    int a, b, k;
    CLR_N = 1'b0;
    START = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_quo", int'(QUO), 0);
    check("rst_rem", int'(REM), 0);
    check("rst_dz", int'(DZ), 0);
    CLR_N = 1'b1;
    @(negedge CLK);

    issue(60, 12);
    issue(61, 12);
    issue(5, 12);
    issue(200, 0);
    issue(0, 7);
    wait_drain();

    // Long run with a stray START mid-operation; BUSY must span 257 cycles.
    issue(255, 1);
    busy_len = 0;
    while (BUSY && busy_len < 2000) begin
      busy_len++;
      if (busy_len == 50) begin
        A = 8'd9; B = 8'd2; START = 1'b1;
      end else begin
        START = 1'b0;
      end
      @(negedge CLK);
    end
    START = 1'b0;
    check("busy_len_255_1", busy_len, 257);
    wait_drain();

    // Abort in the 10th SUB cycle.
    issue(100, 3);
    repeat (9) @(negedge CLK);
    CLR_N = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("abort_busy", int'(BUSY), 0);
    check("abort_done", int'(DONE), 0);
    check("abort_quo", int'(QUO), 0);
    check("abort_rem", int'(REM), 0);
    check("abort_dz", int'(DZ), 0);
    repeat (2) @(negedge CLK);
    CLR_N = 1'b1;
    repeat (5) @(negedge CLK);
    issue(100, 3);
    wait_drain();

    // START held high: back-to-back runs restart two edges after DONE.
    k = edge_cnt + 1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model(50, 7, k));
      k = k + (50 / 7 + 1) + 2;
    end
    A = 8'd50; B = 8'd7; START = 1'b1;
    busy_len = 0;
    while (exp_q.size() != 0 && busy_len < 500) begin
      @(negedge CLK);
      busy_len++;
    end
    START = 1'b0;
    wait_drain();

    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 255);
      case ($urandom_range(0, 3))
        0:       b = 0;
        1:       b = $urandom_range(1, 3);
        default: b = $urandom_range(1, 255);
      endcase
      issue(a, b);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    wait_drain();
    repeat (3) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
